// File: rtl/vga_timing_gen_if.sv
// Purpose: VGA raster bus carrying pixel coordinates, sync, blanking and colour.
// Latency: none, this is a plain bundle of wires.
// Backpressure: none; the raster is free-running and consumers must keep pace.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    // Producer side of the raster.
    modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    // Consumer side of the raster.
    modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    // Producer view used by the timing generator's port.
    modport out    (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Purpose: free-running 800x600@60 VGA raster source with frame/line strobes.
// Latency: zero; out presents the live counter point, all fields aligned.
// Backpressure: none; advances one pixel every clock regardless of consumers.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    output logic  frame_start,
    output logic  line_start,
    vga_if.out    out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 11 bits wide, so totals beyond 2048 cannot be represented.
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_params
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 2048");
    end

    // Decode thresholds carried at 12 bits so a 2048 total still fits.
    localparam logic [11:0] L_H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] L_V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] L_H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] L_V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] L_HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] L_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] L_VS_BEG   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] L_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        L_HS_ON    = (HSYNC_POL != 0);
    localparam logic        L_VS_ON    = (VSYNC_POL != 0);

    logic [10:0] r_h;
    logic [10:0] r_v;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_frame_start;
    logic        r_line_start;

    logic        w_h_last;
    logic        w_v_last;
    logic [10:0] w_h_nxt;
    logic [10:0] w_v_nxt;
    logic [11:0] w_h_nxt_x;
    logic [11:0] w_v_nxt_x;
    logic        w_hs_act;
    logic        w_vs_act;

    assign w_h_last  = ({1'b0, r_h} == L_H_LAST);
    assign w_v_last  = ({1'b0, r_v} == L_V_LAST);
    assign w_h_nxt_x = {1'b0, w_h_nxt};
    assign w_v_nxt_x = {1'b0, w_v_nxt};
    assign w_hs_act  = (w_h_nxt_x >= L_HS_BEG) && (w_h_nxt_x < L_HS_END);
    assign w_vs_act  = (w_v_nxt_x >= L_VS_BEG) && (w_v_nxt_x < L_VS_END);

    // Next raster point: h steps every cycle, v only steps when h wraps.
    always_comb begin
        w_h_nxt = r_h + 11'd1;
        w_v_nxt = r_v;
        if (w_h_last) begin
            w_h_nxt = '0;
            w_v_nxt = w_v_last ? 11'd0 : r_v + 11'd1;
        end
    end

    // Register the counters and every decode of the next point together so
    // all outputs describe the same (h,v); reset presents the (0,0) decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_hsync       <= ~L_HS_ON;
            r_vsync       <= ~L_VS_ON;
            r_frame_start <= 1'b1;
            r_line_start  <= 1'b1;
        end else begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hblnk       <= (w_h_nxt_x >= L_H_ACT);
            r_vblnk       <= (w_v_nxt_x >= L_V_ACT);
            r_hsync       <= w_hs_act ? L_HS_ON : ~L_HS_ON;
            r_vsync       <= w_vs_act ? L_VS_ON : ~L_VS_ON;
            r_frame_start <= (w_h_nxt == 11'd0) && (w_v_nxt == 11'd0);
            r_line_start  <= (w_h_nxt == 11'd0);
        end
    end

    assign out.hcount  = r_h;
    assign out.vcount  = r_v;
    assign out.hblnk   = r_hblnk;
    assign out.vblnk   = r_vblnk;
    assign out.hsync   = r_hsync;
    assign out.vsync   = r_vsync;
    assign out.rgb     = 12'h000;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule
